// File: rtl/rv_pkg.sv
// Shared register-file write-back types: address width, request bundle and source enum.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    WB_EX = 1'b0,
    WB_LD = 1'b1
  } wb_src_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter (execute vs load); grants are combinational from valids.
// After a contended cycle the pointer moves to the loser, so each side wins every other cycle.
module wb_rr_arbiter
  import rv_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    req_ex,
  input  logic    req_ld,
  output logic    gnt_ex,
  output logic    gnt_ld,
  output wb_src_t prio
);

  logic contended;

  assign contended = req_ex & req_ld;
  assign gnt_ex    = req_ex & (~req_ld | (prio == WB_EX));
  assign gnt_ld    = req_ld & (~req_ex | (prio == WB_LD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= WB_EX;
    end else if (contended) begin
      prio <= gnt_ex ? WB_LD : WB_EX;
    end
  end

endmodule

// File: rtl/regs_wb_ctrl.sv
// Write-back controller: arbitrates the register-file write port and tracks pending writes.
// Accept-to-commit is one cycle; the output stage never stalls, so the only backpressure is arbitration loss.
module regs_wb_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_data,
  output logic                  ex_ready,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  ld_ready,
  input  logic                  mark_valid,
  input  logic [REG_ADDR_W-1:0] mark_rd,
  input  logic [REG_ADDR_W-1:0] rs1_select,
  input  logic [REG_ADDR_W-1:0] rs2_select,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [REG_ADDR_W-1:0] reg_write_select,
  output logic [XLEN-1:0]       reg_write_data,
  output logic                  reg_write_control
);

  wb_src_t               prio;
  logic                  fire;
  logic [REG_ADDR_W-1:0] win_rd;
  logic [XLEN-1:0]       win_data;
  logic [NREGS-1:0]      busy;
  logic [NREGS-1:0]      busy_nxt;

  wb_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_ex (ex_valid),
    .req_ld (ld_valid),
    .gnt_ex (ex_ready),
    .gnt_ld (ld_ready),
    .prio   (prio)
  );

  assign fire = ex_ready | ld_ready;

  always_comb begin
    win_rd   = ex_rd;
    win_data = ex_data;
    if (ld_ready) begin
      win_rd   = ld_rd;
      win_data = ld_data;
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_control <= 1'b0;
      reg_write_select  <= '0;
      reg_write_data    <= '0;
    end else begin
      reg_write_control <= fire && (win_rd != '0);
      if (fire && (win_rd != '0)) begin
        reg_write_select <= win_rd;
        reg_write_data   <= win_data;
      end
    end
  end

  // Clear on commit first so a same-cycle mark of that register wins.
  always_comb begin
    busy_nxt = busy;
    if (reg_write_control) begin
      busy_nxt[reg_write_select] = 1'b0;
    end
    if (mark_valid && (mark_rd != '0)) begin
      busy_nxt[mark_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign rs1_busy = busy[rs1_select];
  assign rs2_busy = busy[rs2_select];

endmodule
